// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/exec/mem/writeback control FSM; INSTR_COUNT_EN enables the retired counter
module instr_sequencer #(
    parameter logic [8:0] SP_MAX      = 9'd511,
    parameter int         MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] instr,
    input  logic [8:0]  sP,
    input  logic        memReady,
    output logic        instRegWrite,
    output logic        pcWrite,
    output logic        pcSelect,
    output logic        regWrite,
    output logic        regWriteSelect,
    output logic        memRead,
    output logic        memWrite,
    output logic        spWrite,
    output logic        spSelect,
    output logic [2:0]  phase,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  faultCode,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        FAULT  = 3'd6
    } state_t;

    localparam logic [2:0] OP_JUMP = 3'b000;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state;
    logic [2:0]  opcode;
    logic [7:0]  timeoutCnt;
    logic        faultFlag;
    logic [1:0]  faultCodeReg;
    logic [2:0]  decOp;
    logic        unusedInstrBits;

    // Only the opcode field of the instruction matters to the sequencer.
    assign decOp           = instr[15:13];
    assign unusedInstrBits = ^instr[12:0];

    // Main sequencer: state transitions, opcode capture, memory timeout and sticky fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            opcode       <= 3'b000;
            timeoutCnt   <= 8'd0;
            faultFlag    <= 1'b0;
            faultCodeReg <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (run) state <= FETCH;
                end
                FETCH: begin
                    state <= DECODE;
                end
                DECODE: begin
                    opcode <= decOp;
                    if (decOp == OP_PUSH && sP == SP_MAX) begin
                        state        <= FAULT;
                        faultFlag    <= 1'b1;
                        faultCodeReg <= 2'b01;
                    end else if (decOp == OP_POP && sP == 9'd0) begin
                        state        <= FAULT;
                        faultFlag    <= 1'b1;
                        faultCodeReg <= 2'b10;
                    end else if (decOp == OP_JUMP) begin
                        state <= WB;
                    end else if (!decOp[2]) begin
                        state <= EXEC;
                    end else begin
                        state      <= MEM;
                        timeoutCnt <= 8'd0;
                    end
                end
                EXEC: begin
                    state <= WB;
                end
                MEM: begin
                    if (memReady) begin
                        state <= WB;
                    end else if (timeoutCnt == TIMEOUT_LAST) begin
                        state        <= FAULT;
                        faultFlag    <= 1'b1;
                        faultCodeReg <= 2'b11;
                    end else begin
                        timeoutCnt <= timeoutCnt + 8'd1;
                    end
                end
                WB: begin
                    state <= run ? FETCH : IDLE;
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef INSTR_COUNT_EN
    logic [15:0] retiredCnt;

    // Count every writeback; faulted instructions never reach WB so are not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retiredCnt <= 16'h0000;
        end else if (state == WB) begin
            retiredCnt <= retiredCnt + 16'h0001;
        end
    end

    assign retired = retiredCnt;
`else
    assign retired = 16'h0000;
`endif

    // Moore strobe decode from the state and latched opcode; async reset of state drops strobes at once.
    always_comb begin
        instRegWrite   = 1'b0;
        pcWrite        = 1'b0;
        pcSelect       = 1'b0;
        regWrite       = 1'b0;
        regWriteSelect = 1'b0;
        memRead        = 1'b0;
        memWrite       = 1'b0;
        spWrite        = 1'b0;
        spSelect       = 1'b0;
        case (state)
            FETCH: instRegWrite = 1'b1;
            MEM: begin
                memRead  = (opcode == OP_LD) || (opcode == OP_POP);
                memWrite = (opcode == OP_ST) || (opcode == OP_PUSH);
            end
            WB: begin
                pcWrite        = 1'b1;
                pcSelect       = (opcode == OP_JUMP);
                regWrite       = (opcode != OP_JUMP) && (opcode != OP_ST) && (opcode != OP_PUSH);
                regWriteSelect = (opcode == OP_LD) || (opcode == OP_POP);
                spWrite        = (opcode == OP_PUSH) || (opcode == OP_POP);
                spSelect       = (opcode == OP_PUSH);
            end
            default: ;
        endcase
    end

    assign phase     = state;
    assign busy      = (state != IDLE) && (state != FAULT);
    assign fault     = faultFlag;
    assign faultCode = faultCodeReg;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] instr;
    logic [8:0]  sP;
    logic        memReady;
    logic        instRegWrite;
    logic        pcWrite;
    logic        pcSelect;
    logic        regWrite;
    logic        regWriteSelect;
    logic        memRead;
    logic        memWrite;
    logic        spWrite;
    logic        spSelect;
    logic [2:0]  phase;
    logic        busy;
    logic        fault;
    logic [1:0]  faultCode;
    logic [15:0] retired;

    int nCompared;
    int nMismatched;

    instr_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .instr          (instr),
        .sP             (sP),
        .memReady       (memReady),
        .instRegWrite   (instRegWrite),
        .pcWrite        (pcWrite),
        .pcSelect       (pcSelect),
        .regWrite       (regWrite),
        .regWriteSelect (regWriteSelect),
        .memRead        (memRead),
        .memWrite       (memWrite),
        .spWrite        (spWrite),
        .spSelect       (spSelect),
        .phase          (phase),
        .busy           (busy),
        .fault          (fault),
        .faultCode      (faultCode),
        .retired        (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        memReady = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int memCycles;
        int wbSeen;
        nCompared   = 0;
        nMismatched = 0;
        rst      = 1'b1;
        run      = 1'b0;
        instr    = 16'h0000;
        sP       = 9'd100;
        memReady = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkVal("rst_phase", 32'(phase), 0);
        checkVal("rst_busy", 32'(busy), 0);
        checkVal("rst_fault", 32'({fault, faultCode}), 0);
        checkVal("rst_strobes", 32'({instRegWrite, pcWrite, pcSelect, regWrite, regWriteSelect,
                                     memRead, memWrite, spWrite, spSelect}), 0);
        checkVal("rst_retired", 32'(retired), 0);

        // add: 1,2,3,5,1
        rst   = 1'b0;
        run   = 1'b1;
        instr = 16'h6000;
        step();
        checkVal("add_fetch_phase", 32'(phase), 1);
        checkVal("add_fetch_irw", 32'(instRegWrite), 1);
        step();
        checkVal("add_decode_phase", 32'(phase), 2);
        checkVal("add_decode_pcw", 32'({pcWrite, regWrite}), 0);
        step();
        checkVal("add_exec_phase", 32'(phase), 3);
        checkVal("add_exec_strobes", 32'({pcWrite, regWrite, memRead, memWrite}), 0);
        step();
        checkVal("add_wb_phase", 32'(phase), 5);
        checkVal("add_wb_rw_rws_pcw_pcs", 32'({regWrite, regWriteSelect, pcWrite, pcSelect}), 4'b1010);
        step();
        checkVal("add_next_fetch", 32'(phase), 1);

        // jump: DECODE latches the new instr
        instr = 16'h0005;
        step();
        checkVal("jmp_decode_phase", 32'(phase), 2);
        step();
        checkVal("jmp_wb_phase", 32'(phase), 5);
        checkVal("jmp_wb_pcw_pcs_rw", 32'({pcWrite, pcSelect, regWrite}), 3'b110);
        run = 1'b0;
        step();
        checkVal("jmp_idle_phase", 32'(phase), 0);
        checkVal("jmp_idle_busy", 32'(busy), 0);

        // ld with 3 wait cycles -> 4 MEM cycles
        instr = 16'h8000;
        run   = 1'b1;
        step();
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            checkVal($sformatf("ld_mem%0d_phase", i), 32'(phase), 4);
            checkVal($sformatf("ld_mem%0d_rd_wr", i), 32'({memRead, memWrite}), 2'b10);
            instr = 16'h2000;
            if (i == 3) memReady = 1'b1;
            step();
        end
        checkVal("ld_wb_phase", 32'(phase), 5);
        checkVal("ld_wb_rw_rws_rd", 32'({regWrite, regWriteSelect, memRead}), 3'b110);
        memReady = 1'b0;
        run      = 1'b0;
        step();
        checkVal("ld_idle_phase", 32'(phase), 0);

        // push with room: immediate memReady -> sp update
        instr    = 16'hC000;
        sP       = 9'd100;
        run      = 1'b1;
        memReady = 1'b1;
        step();
        step();
        step();
        checkVal("push_mem_rd_wr", 32'({phase, memRead, memWrite}), {3'd4, 2'b01});
        run = 1'b0;
        step();
        checkVal("push_wb_spw_sps_rw", 32'({phase, spWrite, spSelect, regWrite}), {3'd5, 3'b110});
        memReady = 1'b0;
        step();

        // push overflow
        sP  = 9'd511;
        run = 1'b1;
        step();
        step();
        step();
        checkVal("ovf_phase", 32'(phase), 6);
        checkVal("ovf_fault_code", 32'({fault, faultCode}), 3'b101);
        checkVal("ovf_spw_busy", 32'({spWrite, busy}), 0);
        step();
        step();
        checkVal("ovf_sticky", 32'({phase, fault, faultCode}), {3'd6, 3'b101});
        doReset();
        checkVal("ovf_cleared", 32'({phase, fault, faultCode}), 0);

        // pop underflow
        instr = 16'hE000;
        sP    = 9'd0;
        run   = 1'b1;
        step();
        step();
        step();
        checkVal("unf_phase_code", 32'({phase, fault, faultCode}), {3'd6, 3'b110});
        step();
        checkVal("unf_sticky", 32'({phase, faultCode}), {3'd6, 2'b10});
        doReset();

        // st timeout
        instr = 16'hA000;
        sP    = 9'd100;
        run   = 1'b1;
        step();
        step();
        step();
        memCycles = 0;
        for (int i = 0; i < 40 && phase == 3'd4; i++) begin
            memCycles++;
            step();
        end
        checkVal("tmo_mem_cycles", 32'(memCycles), 15);
        checkVal("tmo_phase_code", 32'({phase, fault, faultCode}), {3'd6, 3'b111});
        checkVal("tmo_memwrite", 32'(memWrite), 0);
        doReset();

        // async reset mid-MEM
        run = 1'b1;
        step();
        step();
        step();
        checkVal("arst_pre_memwrite", 32'({phase, memWrite}), {3'd4, 1'b1});
        #2 rst = 1'b1;
        #1;
        checkVal("arst_memwrite", 32'(memWrite), 0);
        checkVal("arst_phase", 32'(phase), 0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;

        // three adds then stop
        instr  = 16'h6000;
        run    = 1'b1;
        wbSeen = 0;
        for (int i = 0; i < 30 && wbSeen < 3; i++) begin
            step();
            if (phase == 3'd5) begin
                wbSeen++;
                if (wbSeen == 3) run = 1'b0;
            end
        end
        checkVal("cnt_wb_seen", 32'(wbSeen), 3);
        step();
        checkVal("cnt_idle_phase", 32'(phase), 0);
`ifdef INSTR_COUNT_EN
        checkVal("cnt_retired", 32'(retired), 3);
`else
        checkVal("cnt_retired", 32'(retired), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control sequencer for the 16-bit accumulator-free register datapath; replaces the free-running two-phase toggle with an explicit FSM.
- Sequences instruction register load, ALU execute, data-memory access (ld/st/push/pop) with a ready handshake, and register/PC/SP writeback.
- Detects stack overflow/underflow and memory timeout, and parks the datapath in a sticky fault state.

Parameters:
- SP_MAX, 9'd511, highest legal stack pointer value; push at SP_MAX is an overflow.
- MEM_TIMEOUT, 15, maximum MEM-state cycles waiting for memReady before a timeout fault (range 1..255).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- run  input  1  1 = fetch/execute instructions; sampled only in IDLE and WB
- instr  input  16  instruction register output; opcode = instr[15:13]
- sP  input  9  current stack pointer value
- memReady  input  1  data memory has completed the current read/write
- instRegWrite  output  1  load instruction register
- pcWrite  output  1  update PC
- pcSelect  output  1  1 = PC takes jump address
- regWrite  output  1  register file write strobe
- regWriteSelect  output  1  1 = writeback from memory, 0 = from ALU
- memRead  output  1  data memory read request
- memWrite  output  1  data memory write request
- spWrite  output  1  update stack pointer
- spSelect  output  1  1 = push (SP+1), 0 = pop (SP-1)
- phase  output  3  current state encoding
- busy  output  1  1 in any state except IDLE and FAULT
- fault  output  1  sticky fault flag
- faultCode  output  2  01 overflow, 10 underflow, 11 memory timeout, 00 none
- retired  output  16  retired-instruction count (see Optional Feature)

Behaviour:
- Opcodes: 000 jump, 001 or, 010 and, 011 add, 100 ld, 101 st, 110 push, 111 pop.
- States/encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6; 7 is unreachable and recovers to IDLE next cycle.
- Reset (async): state IDLE, all strobes 0, fault=0, faultCode=00, timeout counter 0, opcode register 000, retired 0. Reset mid-instruction aborts immediately; strobes drop in the same cycle rst rises.
- All outputs are Moore: decoded from the state register and the opcode register only.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH: instRegWrite=1 -> DECODE.
- DECODE: latch instr[15:13] into the opcode register. Later changes to instr are ignored until the next DECODE. Priority:
  - push with sP==SP_MAX -> FAULT, code 01.
  - pop with sP==0 -> FAULT, code 10.
  - jump -> WB.
  - or/and/add -> EXEC.
  - ld/st/push/pop -> MEM; timeout counter cleared.
- EXEC: no strobes -> WB.
- MEM:
  - memRead=1 for ld/pop; memWrite=1 for st/push; held steady until memReady=1.
  - memReady=1 -> WB, including in the first MEM cycle.
  - Counter increments each MEM cycle without memReady. memReady=0 when the counter reaches MEM_TIMEOUT-1 -> FAULT, code 11.
  - memReady is ignored in all other states.
- WB:
  - pcWrite=1; pcSelect=1 only for jump.
  - regWrite=1 for or/and/add/ld/pop; regWriteSelect=1 for ld/pop.
  - spWrite=1 for push/pop; spSelect=1 for push.
  - run=1 -> FETCH; run=0 -> IDLE.
- FAULT: fault=1, all strobes 0, busy=0; exits only by rst.
- Latency with immediate memReady:
  - jump 3 cycles (FETCH, DECODE, WB).
  - ALU 4 cycles (FETCH, DECODE, EXEC, WB).
  - ld/st/push/pop 4 cycles (FETCH, DECODE, MEM, WB); each memReady wait cycle adds 1.
- run deasserted mid-instruction: the instruction completes through WB, then IDLE.

Optional Feature:
- Macro INSTR_COUNT_EN.
- Defined: retired increments by 1 on each cycle in WB; 16-bit, wraps 0xFFFF -> 0x0000; reset to 0; not incremented for instructions aborted into FAULT.
- Undefined: retired tied to 16'h0000 and no counter logic is synthesised.

Test Plan:
- Reset then run=1, instr=0x6000 (add), held -> phase sequence 1,2,3,5,1; regWrite=1 with regWriteSelect=0 only in WB; pcWrite=1 only in WB.
- instr=0x0005 (jump), run=1 -> phases 1,2,5; pcSelect=1 and pcWrite=1 in WB; regWrite stays 0.
- instr=0x8000 (ld), memReady low 3 cycles then high -> memRead=1 for 4 MEM cycles, then WB with regWrite=1, regWriteSelect=1.
- push with sP=511 -> FAULT after DECODE, fault=1, faultCode=01, no spWrite. Pop with sP=0 -> faultCode=10. Both remain until rst.
- st with memReady held 0 and MEM_TIMEOUT=15 -> 15 MEM cycles, then FAULT with faultCode=11. rst asserted mid-MEM -> memWrite drops without a clock edge; phase=0.
- With INSTR_COUNT_EN: 3 add instructions then run=0 -> retired=3 and phase=0. Preload to 0xFFFF, retire one more -> 0x0000.
